// File: rtl/serial_ripple_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// Signals:
//   start  - request; the operands are taken on the edge that accepts it
//   a, b   - minuend and subtrahend (WIDTH bits)
//   bin    - borrow-in
//   busy   - high while a subtraction is running
//   done   - one-cycle completion pulse
//   diff   - result, a - b - bin modulo 2^WIDTH
//   bout   - borrow-out, 1 when a < b + bin (unsigned)
// The master modport drives the request side; the slave modport is the subtractor.
interface serial_ripple_subtractor_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - serial_ripple_subtractor_if slave (start/a/b/bin in, busy/done/diff/bout out)
// A subtraction takes WIDTH cycles from the accepting edge to done. A start seen
// during the done cycle is accepted immediately, so the throughput is one
// operation per WIDTH+1 cycles.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | processing bit idx, one bit per edge
// DONE  | result valid, done pulse; start accepted here as in IDLE
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_ripple_subtractor_if.slave bus
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic bit_a, bit_b, bit_d, borrow_nx;

  // Full-subtractor cell for the current bit position.
  assign bit_a     = a_q[idx_q];
  assign bit_b     = b_q[idx_q];
  assign bit_d     = bit_a ^ bit_b ^ borrow_q;
  assign borrow_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & borrow_q);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    idx_d    = idx_q;
    res_d    = res_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          state_d  = RUN;
        end else begin
          state_d  = IDLE;
        end
      end
      RUN: begin
        res_d[idx_q] = bit_d;
        borrow_d     = borrow_nx;
        if (idx_q == LAST_IDX) begin
          // idx is left at the last position so it never wraps.
          diff_d  = res_d;
          bout_d  = borrow_nx;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flags are registered from the next state so they are clean flop outputs.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      idx_q    <= idx_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed bench for serial_ripple_subtractor at WIDTH=4. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_serial_ripple_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  serial_ripple_subtractor_if #(.WIDTH(4)) bus ();

  serial_ripple_subtractor #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Issue one operation and wait (bounded) for its done pulse.
  // Returns at the falling edge inside the done cycle.
  task automatic run_op(input logic [3:0] a_v, input logic [3:0] b_v, input logic bin_v,
                        output logic [3:0] d_v, output logic bo_v, output logic ok);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a_v; bus.b = b_v; bus.bin = bin_v;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 1'b0; d_v = 4'bx; bo_v = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        ok = 1'b1; d_v = bus.diff; bo_v = bus.bout;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.bout, bus.diff} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b bout=%b diff=%b, required all 0",
               bus.busy, bus.done, bus.bout, bus.diff);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_vectors(input string name, input logic [3:0] va [3], input logic [3:0] vb [3],
                              input logic vbin [3], input logic [3:0] vd [3], input logic vbo [3]);
    logic [3:0] d; logic bo; logic ok;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], vbin[k], d, bo, ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s_%0d_timeout: no done seen, required done within 20 cycles", name, k);
      end else if ({bo, d} !== {vbo[k], vd[k]}) begin
        n_fail++;
        $display("FAIL %s_%0d: diff=%b bout=%b, required diff=%b bout=%b",
                 name, k, d, bo, vd[k], vbo[k]);
      end
    end
  endtask

  task automatic test_basic();
    logic [3:0] va [3]   = '{4'b0000, 4'b0101, 4'b0011};
    logic [3:0] vb [3]   = '{4'b0000, 4'b0011, 4'b0101};
    logic       vbin [3] = '{1'b0, 1'b0, 1'b0};
    logic [3:0] vd [3]   = '{4'b0000, 4'b0010, 4'b1110};
    logic       vbo [3]  = '{1'b0, 1'b0, 1'b1};
    test_vectors("basic", va, vb, vbin, vd, vbo);
  endtask

  task automatic test_borrow_in();
    logic [3:0] va [3]   = '{4'b0000, 4'b1111, 4'b1010};
    logic [3:0] vb [3]   = '{4'b0001, 4'b1111, 4'b0101};
    logic       vbin [3] = '{1'b1, 1'b1, 1'b1};
    logic [3:0] vd [3]   = '{4'b1110, 4'b1111, 4'b0100};
    logic       vbo [3]  = '{1'b1, 1'b1, 1'b0};
    test_vectors("borrow_in", va, vb, vbin, vd, vbo);
  endtask

  // Previous result is 0100 / bout 0 (last borrow-in vector).
  task automatic test_handshake();
    logic exp_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_diff [6] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0010};
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b0101; bus.b = 4'b0011; bus.bin = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      n_checks++;
      if ({bus.busy, bus.done, bus.diff} !== {exp_busy[k], exp_done[k], exp_diff[k]}) begin
        n_fail++;
        $display("FAIL handshake_cycle_%0d: busy=%b done=%b diff=%b, required busy=%b done=%b diff=%b",
                 k + 1, bus.busy, bus.done, bus.diff, exp_busy[k], exp_done[k], exp_diff[k]);
      end
    end
  endtask

  // Previous result is 0010 from the handshake test.
  task automatic test_ignore_hold();
    int n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b1000; bus.b = 4'b0001; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b0000; bus.b = 4'b1111; bus.bin = 1'b1;
    n_checks++;
    if (bus.diff !== 4'b0010) begin
      n_fail++;
      $display("FAIL hold_during_run: diff=%b, required 0010", bus.diff);
    end
    @(negedge clk);
    bus.start = 1'b0; bus.a = 4'b0110; bus.b = 4'b1001;
    for (int k = 0; k < 10; k++) begin
      if (bus.done) begin
        n_done++;
        n_checks++;
        if ({bus.bout, bus.diff} !== 5'b0_0111) begin
          n_fail++;
          $display("FAIL ignore_result: diff=%b bout=%b, required diff=0111 bout=0", bus.diff, bus.bout);
        end
      end else if (bus.busy && bus.diff !== 4'b0010) begin
        n_checks++;
        n_fail++;
        $display("FAIL hold_cycle_%0d: diff=%b, required 0010", k, bus.diff);
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_done != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: %0d done pulses, required 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [3]   = '{4'b1100, 4'b0001, 4'b1111};
    logic [3:0] vb [3]   = '{4'b0011, 4'b0010, 4'b0000};
    logic       vbin [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] vd [3]   = '{4'b1001, 4'b1111, 4'b1110};
    logic       vbo [3]  = '{1'b0, 1'b1, 1'b0};
    int k = 0;
    int cyc = 0;
    int last = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = va[0]; bus.b = vb[0]; bus.bin = vbin[0];
    while (k < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        n_checks++;
        if ({bus.bout, bus.diff} !== {vbo[k], vd[k]}) begin
          n_fail++;
          $display("FAIL b2b_result_%0d: diff=%b bout=%b, required diff=%b bout=%b",
                   k, bus.diff, bus.bout, vd[k], vbo[k]);
        end
        n_checks++;
        if (cyc - last != ((k == 0) ? 5 : 5)) begin
          n_fail++;
          $display("FAIL b2b_spacing_%0d: %0d cycles, required 5", k, cyc - last);
        end
        last = cyc;
        k++;
        if (k < 3) begin
          bus.a = va[k]; bus.b = vb[k]; bus.bin = vbin[k];
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    n_checks++;
    if (k != 3) begin
      n_fail++;
      $display("FAIL b2b_done_count: %0d results, required 3", k);
    end
    repeat (2) @(negedge clk);
  endtask

  // Previous result is 1110 / bout 0 from back-to-back.
  task automatic test_reset_mid();
    logic [3:0] d; logic bo; logic ok;
    int n_done = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b1111; bus.b = 4'b0001; bus.bin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_pre_busy: busy=%b, required 1", bus.busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.busy, bus.done, bus.bout, bus.diff} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_mid_async: busy=%b done=%b bout=%b diff=%b, required all 0",
               bus.busy, bus.done, bus.bout, bus.diff);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: %0d busy/done cycles after abort, required 0", n_done);
    end
    run_op(4'b0111, 4'b0010, 1'b0, d, bo, ok);
    n_checks++;
    if (!ok || {bo, d} !== 5'b0_0101) begin
      n_fail++;
      $display("FAIL reset_mid_recover: ok=%b diff=%b bout=%b, required diff=0101 bout=0", ok, d, bo);
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] d; logic bo; logic ok;
    logic [3:0] exp_d; logic exp_bo;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp_d  = 4'((ia - ib - ic) & 15);
          exp_bo = (ia < ib + ic);
          run_op(4'(ia), 4'(ib), 1'(ic), d, bo, ok);
          n_checks++;
          if (!ok || {bo, d} !== {exp_bo, exp_d}) begin
            n_fail++;
            $display("FAIL exhaustive a=%0d b=%0d bin=%0d: ok=%b diff=%b bout=%b, required diff=%b bout=%b",
                     ia, ib, ic, ok, d, bo, exp_d, exp_bo);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_in();
    test_handshake();
    test_ignore_hold();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_ripple_subtractor.md
Name: serial_ripple_subtractor

Overview:
- Multi-cycle, bit-serial subtractor; the inverse operation of the 4-bit ripple carry adder.
- Computes diff = a - b - bin and a borrow-out, one bit per clock, LSB first.
- Uses a start/busy/done handshake.
- Sits beside the adder in the arithmetic datapath where area matters more than latency.

Parameters:
WIDTH, 4, operand and result width in bits (legal range >= 2)

Ports:
clk    input   1      rising-edge clock
rst    input   1      reset, asynchronous, active-high
start  input   1      request; sampled on rising clk edge
a      input   WIDTH  minuend; sampled only with accepted start
b      input   WIDTH  subtrahend; sampled only with accepted start
bin    input   1      borrow-in; sampled only with accepted start
busy   output  1      high while a subtraction is in progress
done   output  1      one-cycle completion pulse
diff   output  WIDTH  result, a - b - bin mod 2^WIDTH
bout   output  1      borrow-out; 1 iff a < b + bin (unsigned)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0. Internal operand registers, borrow and bit index are also cleared.
- States:
  - IDLE: start=1 latches a, b and bin into internal registers, sets borrow=bin and idx=0, and moves to RUN.
  - RUN: one bit per edge at position idx.
    - d = a[idx] ^ b[idx] ^ borrow
    - borrow_next = (~a[idx] & b[idx]) | (~(a[idx] ^ b[idx]) & borrow)
    - d goes into the internal result register; idx increments.
    - On the edge processing idx = WIDTH-1: copy the full result to diff, set bout = borrow_next, set done=1, move to DONE.
  - DONE: lasts exactly one cycle. done=1. start=1 here is accepted exactly as in IDLE (back-to-back, no bubble). Otherwise go to IDLE.
- Timing: start sampled at edge E0; busy=1 from after E0 through E_WIDTH. done=1 for the single cycle after E_WIDTH. Latency start-to-done is WIDTH cycles; throughput is one operation per WIDTH+1 cycles.
- busy is a registered output, 1 iff state==RUN. done is registered, 1 iff state==DONE.
- diff and bout change only on the completion edge. They hold their previous result during RUN and until the next completion.
- start during RUN is ignored. Operand changes during RUN have no effect, since all operands are latched.
- Reset mid-RUN aborts immediately: all outputs return to reset values, and no done is produced for the aborted operation.
- Arithmetic is unsigned, modulo 2^WIDTH.
  - Wrap-around example: 0 - 1 - 0 gives diff = all ones, bout = 1.
  - a == b with bin = 0 gives diff = 0, bout = 0.
- idx width is clog2(WIDTH). The counter must not wrap before completion.

Test Plan:
- Basic vectors (WIDTH=4), each waiting for done:
  - a=0000, b=0000, bin=0 -> diff=0000, bout=0
  - a=0101, b=0011, bin=0 -> diff=0010, bout=0
  - a=0011, b=0101, bin=0 -> diff=1110, bout=1
- Borrow-in cases:
  - a=0000, b=0001, bin=1 -> diff=1110, bout=1
  - a=1111, b=1111, bin=1 -> diff=1111, bout=1
  - a=1010, b=0101, bin=1 -> diff=0100, bout=0
- Handshake timing: start pulse at edge E0 -> busy=1 for exactly 4 cycles, done=1 for exactly 1 cycle after E4, diff stable thereafter.
- Ignore and hold:
  - Start 1000-0001, bin=0. Two cycles later, assert start with a=0000, b=1111 and change inputs -> result diff=0111, bout=0 with one done only.
  - Previous diff is held throughout RUN.
- Back-to-back: start held high continuously with a new vector on each DONE cycle -> 3 consecutive results, each WIDTH+1 cycles apart, each correct, no lost done.
- Reset mid-operation: assert rst two cycles into RUN -> busy=0, done=0, diff=0, bout=0 immediately (asynchronous). Release rst, then start 0111-0010, bin=0 -> diff=0101, bout=0.
- Exhaustive check at WIDTH=4: all a, b, bin combinations against the reference model (a - b - bin) mod 16, with bout = (a < b + bin).
